// File: rtl/nibble_seq_adder.sv
// Multi-cycle unsigned adder built around a single 4-bit full adder.
// Wide operands are latched on the accepting edge and then added one
// nibble per clock, LSB nibble first. The carry is registered between
// nibbles. {cout,sum} = a + b + cin once done pulses.

module fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] y,
  output logic       co
);

  assign {co, y} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last result
// ADD   | one nibble per edge through fa4, idx selects the nibble
// DONE  | final sum/cout valid, done pulses, returns to IDLE next edge
module nibble_seq_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             carry;

  logic [W-1:0]     a_shift;
  logic [W-1:0]     b_shift;
  logic [W-1:0]     lane_mask;
  logic [W-1:0]     lane_y;
  logic [3:0]       fa_a;
  logic [3:0]       fa_b;
  logic [3:0]       fa_y;
  logic             fa_co;
  logic             last;

  // Shifting by the bit offset keeps the nibble select and the result
  // write-back free of variable part-selects.
  assign a_shift   = op_a >> {idx, 2'b00};
  assign b_shift   = op_b >> {idx, 2'b00};
  assign fa_a      = a_shift[3:0];
  assign fa_b      = b_shift[3:0];
  assign lane_mask = W'(4'hF) << {idx, 2'b00};
  assign lane_y    = W'(fa_y) << {idx, 2'b00};
  assign last      = (idx == IDX_W'(NIBBLES - 1));

  fa4 u_fa4 (
    .a  (fa_a),
    .b  (fa_b),
    .ci (carry),
    .y  (fa_y),
    .co (fa_co)
  );

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Sequencer and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ADD;
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
          end
        end
        S_ADD: begin
          sum   <= (sum & ~lane_mask) | lane_y;
          carry <= fa_co;
          if (last) begin
            state <= S_DONE;
            cout  <= fa_co;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/nibble_seq_adder.md
# nibble_seq_adder

Multi-cycle W-bit adder that drives one FA4 4-bit full adder instance, one nibble per clock, LSB nibble first, with the carry registered between nibbles. It sits directly upstream of FA4: it latches wide operands, feeds FA4's A/B/Ci each cycle, and collects Y/Co into the result register. The datapath stays one FA4 wide, and any operand width that is a multiple of 4 is handled by iteration.

## Interface
- NIBBLES, default 4: number of 4-bit nibbles per operand.
- W = 4*NIBBLES is derived and is not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin an addition; sampled only in IDLE.
- a  in  W  operand A; sampled on the accepting edge.
- b  in  W  operand B; sampled on the accepting edge.
- cin  in  1  carry-in to nibble 0; sampled on the accepting edge.
- busy  out  1  high while in ADD or DONE.
- done  out  1  one-cycle pulse; high only in DONE.
- sum  out  W  result, registered.
- cout  out  1  carry out of the top nibble, registered.

## Operation
- FSM states:
  - IDLE: start=1 moves to ADD. The edge latches a, b, cin into op_a, op_b, carry; clears idx, sum and cout.
  - ADD: each edge writes FA4.Y into sum[4*idx+3:4*idx], loads carry with FA4.Co, and increments idx. On the edge where idx==NIBBLES-1, the FSM moves to DONE and cout is loaded with FA4.Co.
  - DONE: next edge returns unconditionally to IDLE.
- FA4 inputs are combinational from registers:
  - A = op_a nibble idx
  - B = op_b nibble idx
  - Ci = carry
- idx width is clog2(NIBBLES), minimum 1 bit. idx resets to 0 and never exceeds NIBBLES-1.
- Arithmetic is unsigned: {cout,sum} = a + b + cin, modulo 2^(W+1). No overflow flag.
- start is ignored in ADD and DONE. No queuing, and in-flight operands are unaffected.
- a, b and cin may change freely after the accepting edge.
- sum and cout hold their value from DONE through IDLE until the next accepted start clears them. While busy, sum is partially filled and must not be consumed.
- reset has priority over every other input in every state, and aborts an in-flight addition:
  - state, idx, carry, op_a, op_b → 0 / IDLE
  - sum → 0, cout → 0, busy → 0, done → 0

## Timing
- Edge E0 with start=1 in IDLE is the accepting edge; busy is high from E0 onward.
- Edges E1..E_NIBBLES each process nibble k-1.
- After E_NIBBLES: done=1 and the final sum/cout are valid for exactly one cycle.
- After E_NIBBLES+1: IDLE, busy=0, done=0.
- Latency from the accepting edge to the done cycle is NIBBLES edges (4 for the default). Throughput is one addition per NIBBLES+2 cycles.
- A start held high continuously is accepted on the first IDLE edge after DONE.
- reset asserted on any edge yields the reset values after that edge. reset and start high on the same edge: reset wins, and start is not accepted.

## Test plan
- a=16'hFFFF, b=16'h0001, cin=0 → after 4 edges: done=1, sum=16'h0000, cout=1. done is high exactly one cycle, and busy drops one cycle later.
- a=16'h1234, b=16'h4321, cin=1 → sum=16'h5556, cout=0. sum and cout must be held through a following 10-cycle IDLE.
- Mid-op disturbance: accept a=16'h00FF, b=16'h0001, cin=0. At E2, pulse start with a=16'hAAAA, and change a/b. → Result still sum=16'h0100, cout=0, and the second start is not accepted.
- reset at E2 of an addition → next cycle: busy=0, done=0, sum=0, cout=0, state IDLE. A new start one cycle later completes correctly: 16'h8000+16'h8000 → sum=0, cout=1.
- start held high for 20 cycles → accepts occur exactly every 6 cycles (NIBBLES+2). Each yields a correct result for the operands present on its accepting edge.
- 256 random (a, b) pairs, with cin=0 for the first 128 and cin=1 for the rest → at every done, {cout,sum} === a+b+cin. Any mismatch is reported. Repeat with NIBBLES=1 and NIBBLES=8.
